spi_master_fifo: RTL and testbench

Parametrised SPI master, the next generation of the fixed 8-bit RFID SPI port. It adds configurable word width and FIFO depth, runtime CPOL/CPHA/LSB-first selection, a programmable SCLK divider and N slave selects. Sits on the CPU peripheral bus behind the same register-style slave interface and drives off-chip SPI devices such as the RFID reader.

---
 rtl/spi_master_fifo.sv | 272 +++++++++++++++++++++++++++
 tb/tb_spi_master_fifo.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_fifo.sv
// spi_master_fifo: SPI master with TX/RX FIFOs, runtime CPOL/CPHA/LSB-first, SCLK divider
// and N slave selects, behind a register bus.
// Bus: spi_select, mem_addr, read_n, write_n, data_from_cpu -> data_to_cpu, irq.
// SPI: MISO in; MOSI, SCLK, SS_n out.
// Build option: SPI_LOOPBACK_EN enables CONTROL[7] LOOP (MOSI fed back to the sampler).
module spi_master_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SLAVES = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_select,
  input  logic [2:0]            mem_addr,
  input  logic                  read_n,
  input  logic                  write_n,
  input  logic [15:0]           data_from_cpu,
  output logic [15:0]           data_to_cpu,
  output logic                  irq,
  input  logic                  MISO,
  output logic                  MOSI,
  output logic                  SCLK,
  output logic [NUM_SLAVES-1:0] SS_n
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = $clog2(2 * DATA_WIDTH) + 1;
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_WIDTH - 1);
`ifdef SPI_LOOPBACK_EN
  localparam int CW = 8;
`else
  localparam int CW = 7;
`endif

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;

  state_t state, state_nx;

  logic wr, rd;
  logic unused_bits;

  // a cycle with both strobes low counts as a write only
  assign wr = spi_select & ~write_n;
  assign rd = spi_select & ~read_n & write_n;
  assign unused_bits = ^data_from_cpu;

  logic [CW-1:0]         ctrl_reg, ctrl_act, cfg;
  logic [DIV_WIDTH-1:0]  div_reg, div_act, cnt;
  logic [NUM_SLAVES-1:0] mask;
  logic                  toe, roe;

  // config written while busy is held off until the FSM is back in IDLE
  assign cfg = (state == IDLE) ? ctrl_reg : ctrl_act;

  logic cpol, cpha, lsb, sso;
  assign cpol = cfg[0];
  assign cpha = cfg[1];
  assign lsb  = cfg[2];
  assign sso  = cfg[3];

  // TX FIFO
  logic [DATA_WIDTH-1:0] tx_mem [FIFO_DEPTH];
  logic [AW:0]           tx_wp, tx_rp, tx_lvl;
  logic                  tx_empty, tx_full;
  logic                  tx_push, tx_pop, toe_set;
  logic [DATA_WIDTH-1:0] tx_word;

  assign tx_lvl   = tx_wp - tx_rp;
  assign tx_empty = (tx_lvl == '0);
  assign tx_full  = tx_lvl[AW];
  assign tx_word  = tx_mem[tx_rp[AW-1:0]];

  // RX FIFO
  logic [DATA_WIDTH-1:0] rx_mem [FIFO_DEPTH];
  logic [AW:0]           rx_wp, rx_rp, rx_lvl;
  logic                  rx_empty, rx_full;
  logic                  rx_req, rx_push, rx_pop, roe_set;

  assign rx_lvl   = rx_wp - rx_rp;
  assign rx_empty = (rx_lvl == '0);
  assign rx_full  = rx_lvl[AW];

  logic wr_tx;
  assign wr_tx   = wr & (mem_addr == 3'd1);
  assign tx_push = wr_tx & (~tx_full | tx_pop);
  assign toe_set = wr_tx & tx_full & ~tx_pop;
  assign rx_pop  = rd & (mem_addr == 3'd0) & ~rx_empty;
  assign rx_push = rx_req & (~rx_full | rx_pop);
  assign roe_set = rx_req & rx_full & ~rx_pop;

  // shift engine
  logic [DIV_WIDTH-1:0]  unused_div;
  logic [EW-1:0]         ecnt;
  logic [DATA_WIDTH-1:0] tx_sh, rx_sh;
  logic                  tick, load, edge_en, go_idle;
  logic                  lead, shift_now, sample_now, din;

  assign unused_div = '0;
  assign tick = (cnt == div_act);
  // LEAD leaves ecnt at 0, so even counts are leading edges
  assign lead       = ~ecnt[0];
  assign shift_now  = edge_en & (lead ? cpha : ~cpha);
  assign sample_now = edge_en & (lead ? ~cpha : cpha);
  assign tx_pop     = load;

`ifdef SPI_LOOPBACK_EN
  assign din = cfg[7] ? MOSI : MISO;
`else
  assign din = MISO;
`endif

  function automatic logic first_bit(
    input logic [DATA_WIDTH-1:0] w,
    input logic                  l
  );
    return l ? w[0] : w[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] next_word(
    input logic [DATA_WIDTH-1:0] w,
    input logic                  l
  );
    return l ? (w >> 1) : (w << 1);
  endfunction

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // next state
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (!tx_empty) state_nx = LEAD;
      LEAD:  if (tick) state_nx = SHIFT;
      SHIFT: if (tick && ecnt == LAST_EDGE) state_nx = TRAIL;
      TRAIL: if (tick) state_nx = tx_empty ? IDLE : LEAD;
      default: state_nx = IDLE;
    endcase
  end

  // FSM strobes
  always_comb begin
    load    = 1'b0;
    edge_en = 1'b0;
    rx_req  = 1'b0;
    go_idle = 1'b0;
    unique case (state)
      IDLE:  load = ~tx_empty;
      LEAD:  edge_en = tick;
      SHIFT: edge_en = tick;
      TRAIL: begin
        rx_req  = tick;
        load    = tick & ~tx_empty;
        go_idle = tick & tx_empty;
      end
      default: ;
    endcase
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[AW-1:0]] <= data_from_cpu[DATA_WIDTH-1:0];
    if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_sh;
  end

  // SPI datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      ecnt     <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      MOSI     <= 1'b0;
      SCLK     <= 1'b0;
      SS_n     <= '1;
      ctrl_act <= '0;
      div_act  <= '0;
    end else begin
      if (state == IDLE) begin
        ctrl_act <= ctrl_reg;
        div_act  <= div_reg;
      end
      cnt <= (state == IDLE || tick) ? '0 : cnt + 1'b1;
      if (load)         ecnt <= '0;
      else if (edge_en) ecnt <= ecnt + 1'b1;
      if (state == IDLE) SCLK <= cpol;
      else if (edge_en)  SCLK <= lead ? ~cpol : cpol;
      if (load) begin
        if (cpha) begin
          tx_sh <= tx_word;
        end else begin
          MOSI  <= first_bit(tx_word, lsb);
          tx_sh <= next_word(tx_word, lsb);
        end
      end else if (shift_now) begin
        MOSI  <= first_bit(tx_sh, lsb);
        tx_sh <= next_word(tx_sh, lsb);
      end
      if (sample_now)
        rx_sh <= lsb ? {din, rx_sh[DATA_WIDTH-1:1]}
                     : {rx_sh[DATA_WIDTH-2:0], din};
      if (load)
        SS_n <= ~mask;
      else if (state == IDLE || go_idle)
        SS_n <= sso ? ~mask : '1;
    end
  end

  // status and read mux
  logic [15:0] status, rd_data;
  logic        tmt, trdy, rrdy, err;

  assign tmt  = tx_empty & (state == IDLE);
  assign trdy = ~tx_full;
  assign rrdy = ~rx_empty;
  assign err  = toe | roe;
  assign status = {2'b00, 4'(rx_lvl), 4'(tx_lvl),
                   err, roe, toe, rrdy, trdy, tmt};

  always_comb begin
    rd_data = '0;
    unique case (mem_addr)
      3'd0: if (!rx_empty) rd_data = 16'(rx_mem[rx_rp[AW-1:0]]);
      3'd2: rd_data = status;
      3'd3: rd_data = 16'(ctrl_reg);
      3'd4: rd_data = 16'(div_reg);
      3'd5: rd_data = 16'(mask);
      default: ;
    endcase
  end

  // bus registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_reg    <= '0;
      div_reg     <= '0;
      mask        <= NUM_SLAVES'(1);
      toe         <= 1'b0;
      roe         <= 1'b0;
      tx_wp       <= '0;
      tx_rp       <= '0;
      rx_wp       <= '0;
      rx_rp       <= '0;
      data_to_cpu <= '0;
      irq         <= 1'b0;
    end else begin
      if (wr) begin
        unique case (mem_addr)
          3'd3: ctrl_reg <= data_from_cpu[CW-1:0];
          3'd4: div_reg  <= data_from_cpu[DIV_WIDTH-1:0];
          3'd5: mask     <= data_from_cpu[NUM_SLAVES-1:0];
          default: ;
        endcase
      end
      if (toe_set)                          toe <= 1'b1;
      else if (wr && mem_addr == 3'd2)      toe <= 1'b0;
      if (roe_set)                          roe <= 1'b1;
      else if (wr && mem_addr == 3'd2)      roe <= 1'b0;
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      if (rd) data_to_cpu <= rd_data;
      irq <= (trdy & cfg[4]) | (rrdy & cfg[5]) | (err & cfg[6]);
    end
  end

endmodule

// File: tb/tb_spi_master_fifo.sv
// tb_spi_master_fifo: directed bench for spi_master_fifo (default parameters).
// Drives the register bus, models a mode-0 slave and an echo wire, checks hand values.
module tb_spi_master_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel = 1'b0;
  logic        rd_n = 1'b1;
  logic        wr_n = 1'b1;
  logic [2:0]  addr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] rdata;
  logic        irq, mosi, sclk, miso;
  logic [0:0]  ss_n;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  spi_master_fifo dut (
    .clk(clk), .reset(rst), .spi_select(sel), .mem_addr(addr),
    .read_n(rd_n), .write_n(wr_n), .data_from_cpu(wdata),
    .data_to_cpu(rdata), .irq(irq), .MISO(miso), .MOSI(mosi),
    .SCLK(sclk), .SS_n(ss_n)
  );

  // 0: mode-0 slave, 1: echo of MOSI, 2: held low
  int       msel = 1;
  logic [7:0] slv_word = '0;
  int       sbit = 7;
  logic     slv_bit = 1'b0;

  assign miso = (msel == 0) ? slv_bit : (msel == 1) ? mosi : 1'b0;

  always @(negedge ss_n[0]) begin
    sbit = 7;
    slv_bit = slv_word[7];
  end

  always @(negedge sclk) begin
    if (!ss_n[0] && sbit > 0) begin
      sbit = sbit - 1;
      slv_bit = slv_word[sbit];
    end
  end

  logic [7:0] cap = '0;
  int  ncap = 0;
  int  ss_rise = 0;
  time t1 = 0;
  time t2 = 0;

  always @(posedge sclk) begin
    if (!ss_n[0]) begin
      cap = {cap[6:0], mosi};
      ncap = ncap + 1;
      if (ncap == 1) t1 = $time;
      if (ncap == 2) t2 = $time;
    end
  end

  always @(posedge ss_n[0]) ss_rise = ss_rise + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    sel = 1'b1; wr_n = 1'b0; addr = a; wdata = d;
    @(negedge clk);
    sel = 1'b0; wr_n = 1'b1;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    sel = 1'b1; rd_n = 1'b0; addr = a;
    @(negedge clk);
    sel = 1'b0; rd_n = 1'b1;
    d = rdata;
  endtask

  task automatic wait_idle(input string tag);
    logic [15:0] s;
    int n;
    n = 0;
    s = '0;
    do begin
      bus_rd(3'd2, s);
      n++;
    end while (!s[0] && n < 400);
    chk(tag, 32'(s[0]), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  logic [7:0] mode_ctrl [3];
  logic [7:0] mode_word [3];

  initial begin
    logic [15:0] v;
    int n;
    mode_ctrl[0] = 8'h06; mode_word[0] = 8'h81;
    mode_ctrl[1] = 8'h05; mode_word[1] = 8'h81;
    mode_ctrl[2] = 8'h07; mode_word[2] = 8'h4B;

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rdata", 32'(rdata), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_mosi", 32'(mosi), 32'h0);
    chk("rst_sclk", 32'(sclk), 32'h0);
    chk("rst_ss", 32'(ss_n), 32'h1);
    rst = 1'b0;
    bus_rd(3'd2, v); chk("rst_status", 32'(v), 32'h0003);
    bus_rd(3'd0, v); chk("rx_empty_rd", 32'(v), 32'h0);
    bus_rd(3'd2, v); chk("no_pop_status", 32'(v), 32'h0003);
    bus_rd(3'd3, v); chk("rst_ctrl", 32'(v), 32'h0);
    bus_rd(3'd4, v); chk("rst_div", 32'(v), 32'h0);
    bus_rd(3'd5, v); chk("rst_mask", 32'(v), 32'h1);

    // mode 0, div=1, slave returns 0x3C
    msel = 0;
    slv_word = 8'h3C;
    bus_wr(3'd4, 16'd1);
    bus_wr(3'd3, 16'h0);
    cap = '0; ncap = 0;
    bus_wr(3'd1, 16'h00A5);
    wait_idle("m0_idle");
    chk("m0_mosi_bits", 32'(cap), 32'hA5);
    chk("m0_edges", 32'(ncap), 32'd8);
    chk("m0_period", 32'(t2 - t1), 32'd40);
    bus_rd(3'd2, v); chk("m0_status", 32'(v), 32'h0407);
    chk("m0_irq_off", 32'(irq), 32'h0);
    bus_rd(3'd0, v); chk("m0_rx", 32'(v), 32'h3C);
    chk("m0_ss_idle", 32'(ss_n), 32'h1);

    // modes 1/2/3 with LSB first into an echo wire
    msel = 1;
    for (int m = 0; m < 3; m++) begin
      bus_wr(3'd3, 16'(mode_ctrl[m]));
      @(negedge clk);
      chk("mode_idle_pol", 32'(sclk), 32'(mode_ctrl[m][0]));
      bus_wr(3'd1, 16'(mode_word[m]));
      wait_idle("mode_idle");
      bus_rd(3'd0, v); chk("mode_rx", 32'(v), 32'(mode_word[m]));
      chk("mode_end_pol", 32'(sclk), 32'(mode_ctrl[m][0]));
    end

    // burst: 6 writes, first is popped at once, 4 queue, 6th overflows
    bus_wr(3'd3, 16'h0);
    bus_wr(3'd4, 16'h0);
    ss_rise = 0;
    for (int i = 1; i <= 6; i++) bus_wr(3'd1, 16'(i * 16'h11));
    wait_idle("burst_idle");
    chk("burst_ss_rises", 32'(ss_rise), 32'd1);
    bus_rd(3'd2, v); chk("burst_status", 32'(v), 32'h103F);
    for (int i = 1; i <= 4; i++) begin
      bus_rd(3'd0, v); chk("burst_rx", 32'(v), 32'(i * 16'h11));
    end
    bus_rd(3'd2, v); chk("burst_drained", 32'(v), 32'h003B);
    bus_wr(3'd2, 16'h0);
    bus_rd(3'd2, v); chk("err_cleared", 32'(v), 32'h0003);

    // receive interrupt
    bus_wr(3'd3, 16'h0020);
    @(negedge clk);
    chk("irq_quiet", 32'(irq), 32'h0);
    bus_wr(3'd1, 16'h005A);
    n = 0;
    while (!irq && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("irq_set", 32'(irq), 32'h1);
    bus_rd(3'd0, v); chk("irq_rx", 32'(v), 32'h5A);
    @(negedge clk);
    chk("irq_drop", 32'(irq), 32'h0);
    bus_wr(3'd3, 16'h0);

    // reset in the middle of a transfer
    bus_wr(3'd4, 16'd3);
    ncap = 0;
    bus_wr(3'd1, 16'h00C3);
    n = 0;
    while (ncap < 4 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reached", 32'(ncap >= 4), 32'h1);
    chk("mid_ss_low", 32'(ss_n), 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("abort_ss", 32'(ss_n), 32'h1);
    chk("abort_sclk", 32'(sclk), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus_rd(3'd2, v); chk("abort_status", 32'(v), 32'h0003);
    bus_rd(3'd4, v); chk("abort_div", 32'(v), 32'h0);

`ifdef SPI_LOOPBACK_EN
    msel = 2;
    bus_wr(3'd3, 16'h0080);
    bus_wr(3'd1, 16'h005A);
    wait_idle("loop_idle");
    bus_rd(3'd0, v); chk("loop_rx", 32'(v), 32'h5A);
`else
    bus_wr(3'd3, 16'h0080);
    bus_rd(3'd3, v); chk("loop_absent", 32'(v), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
